// File: rtl/demux_route_ctrl_if.sv
// ---------------------------------------------------------------------------
// demux_route_ctrl_if
//
// Bundles the input link handshake, the demux-facing output handshake and the
// status lines of one wormhole steering controller.
//
// Signals:
//   in_flit   [FLIT_W] incoming flit (type in the top two bits)
//   in_valid           in_flit is valid
//   in_ready           controller accepts in_flit this cycle
//   out_flit  [FLIT_W] buffered flit for the demux data input
//   out_sel   [2]      demux select, the locked route
//   out_valid [4]      one-hot valid toward the selected output
//   out_ready [4]      per-output ready from downstream
//   busy               a route is locked
//   err                one-cycle protocol violation pulse
//
// Modports:
//   master  the environment: drives the input link and downstream readies
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface demux_route_ctrl_if #(
    parameter int FLIT_W = 16
);
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] out_flit;
    logic [1:0]        out_sel;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic              busy;
    logic              err;

    modport master (
        output in_flit,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_flit,
        input  out_sel,
        input  out_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  in_flit,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_flit,
        output out_sel,
        output out_valid,
        output busy,
        output err
    );
endinterface

// File: rtl/demux_route_ctrl.sv
// ---------------------------------------------------------------------------
// demux_route_ctrl
//
// Wormhole steering controller for one router input port. The destination of
// each head (or single-flit) packet is decoded and locked as the demux select
// until the tail flit has been accepted. Every flit passes through a one-entry
// output buffer; a drain and a refill can happen in the same cycle, so the
// controller streams one flit per cycle when downstream is ready.
//
// Parameters:
//   FLIT_W    flit width including the 2-bit type field (top bits)
//   DEST_LSB  LSB of the 2-bit destination field in head/single flits
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   demux_route_ctrl_if.slave: input link, demux outputs, busy, err
// ---------------------------------------------------------------------------
module demux_route_ctrl #(
    parameter int FLIT_W   = 16,
    parameter int DEST_LSB = 0
) (
    input  logic                clk,
    input  logic                rst,
    demux_route_ctrl_if.slave   bus
);

    // Parameter sanity: the destination field must lie below the type field.
    generate
        if (FLIT_W < 4) begin : g_bad_width
            $error("demux_route_ctrl: FLIT_W must be at least 4");
        end
        if (DEST_LSB < 0 || DEST_LSB + 1 >= FLIT_W - 2) begin : g_bad_dest
            $error("demux_route_ctrl: destination field overlaps the type field");
        end
    endgenerate

    localparam logic [1:0] TYPE_SINGLE = 2'b00;
    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_BODY   = 2'b10;
    localparam logic [1:0] TYPE_TAIL   = 2'b11;

    typedef enum logic {
        IDLE,
        ROUTE
    } state_t;

    state_t            state;
    logic              buf_full;
    logic [1:0]        sel_q;
    logic [FLIT_W-1:0] flit_q;
    logic              err_q;

    logic [1:0] flit_type;
    logic [1:0] dest;
    logic       in_ready;
    logic       accept;
    logic       drain;
    logic       is_start;
    logic       legal;

    assign flit_type = bus.in_flit[FLIT_W-1 -: 2];
    assign dest      = bus.in_flit[DEST_LSB +: 2];

    // The buffer can take a new flit when empty or when its current flit
    // leaves this cycle. Because a refill of a full buffer needs the old flit
    // to drain, the select never changes under an undrained flit.
    assign in_ready = ~buf_full | bus.out_ready[sel_q];
    assign accept   = bus.in_valid & in_ready;
    assign drain    = buf_full & bus.out_ready[sel_q];

    // Head and single flits open a packet and are only legal with no route
    // locked; body and tail flits are only legal inside a locked route.
    assign is_start = (flit_type == TYPE_SINGLE) | (flit_type == TYPE_HEAD);
    assign legal    = (state == IDLE) ? is_start : ~is_start;

    assign bus.in_ready  = in_ready;
    assign bus.out_flit  = flit_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = buf_full ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.busy      = (state == ROUTE);
    assign bus.err       = err_q;

    // Route FSM and output buffer. A legal accepted flit always reloads the
    // buffer, overriding a same-cycle drain; an illegal accepted flit is
    // swallowed and only raises err in the following cycle. Route state and
    // select are touched only by legal flits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            buf_full <= 1'b0;
            sel_q    <= 2'b00;
            flit_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept & ~legal;

            if (drain) begin
                buf_full <= 1'b0;
            end

            if (accept && legal) begin
                buf_full <= 1'b1;
                flit_q   <= bus.in_flit;
                case (flit_type)
                    TYPE_SINGLE: begin
                        sel_q <= dest;
                    end
                    TYPE_HEAD: begin
                        sel_q <= dest;
                        state <= ROUTE;
                    end
                    TYPE_BODY: begin
                    end
                    TYPE_TAIL: begin
                        state <= IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
